// File: rtl/mem_access_ctrl_if.sv
// Memory access unit bus bundle.
// Groups the datapath side (Bus, ldMAR, ldMDR, mioEn, rw, MAROut, MDROut, R) and the
// req/ack memory side (memReq, memWe, memAddr, memWData, memRData, memAck, memErr).
//   slave  : view used by mem_access_ctrl (datapath/memory inputs in, registers out)
//   master : view used by the driver of the control and memory inputs
interface mem_access_ctrl_if;
  logic [15:0] Bus;
  logic        ldMAR;
  logic        ldMDR;
  logic        mioEn;
  logic        rw;
  logic [15:0] memRData;
  logic        memAck;
  logic [15:0] MAROut;
  logic [15:0] MDROut;
  logic        R;
  logic        memReq;
  logic        memWe;
  logic [15:0] memAddr;
  logic [15:0] memWData;
  logic        memErr;

  modport slave (
    input  Bus, ldMAR, ldMDR, mioEn, rw, memRData, memAck,
    output MAROut, MDROut, R, memReq, memWe, memAddr, memWData, memErr
  );

  modport master (
    output Bus, ldMAR, ldMDR, mioEn, rw, memRData, memAck,
    input  MAROut, MDROut, R, memReq, memWe, memAddr, memWData, memErr
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// LC-3 memory access unit. Owns MAR/MDR and runs one req/ack memory cycle per mioEn
// assertion, returning a one-cycle ready pulse R. A WAIT that sees no memAck within
// TIMEOUT cycles is aborted: R still pulses and the sticky memErr flag is set.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : mem_access_ctrl_if.slave (datapath controls in, MAR/MDR/R out, memory req/ack)
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255  // 1..255
) (
  input logic               clk,
  input logic               reset,
  mem_access_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StWait, StReady} state_e;

  state_e      state_q, state_d;
  logic [15:0] mar_q, mar_d;
  logic [15:0] mdr_q, mdr_d;
  logic        req_q, req_d;
  logic        we_q, we_d;     // also holds rw captured at access start
  logic        r_q, r_d;
  logic        err_q, err_d;
  logic        armed_q, armed_d;
  logic [7:0]  cnt_q, cnt_d;

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      mar_q   <= 16'h0000;
      mdr_q   <= 16'h0000;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      r_q     <= 1'b0;
      err_q   <= 1'b0;
      armed_q <= 1'b1;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      req_q   <= req_d;
      we_q    <= we_d;
      r_q     <= r_d;
      err_q   <= err_d;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    req_d   = req_q;
    we_d    = we_q;
    r_d     = 1'b0;
    err_d   = err_q;
    // Re-arm whenever mioEn is low, so one held mioEn yields exactly one access.
    armed_d = armed_q | ~bus.mioEn;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (bus.ldMAR) mar_d = bus.Bus;
        if (bus.ldMDR && !bus.mioEn) mdr_d = bus.Bus;
        if (bus.mioEn && armed_q) begin
          req_d   = 1'b1;
          we_d    = bus.rw;
          cnt_d   = 8'd0;
          state_d = StWait;
        end
      end

      // Address and data stay frozen; only a completing read may update MDR.
      StWait: begin
        if (bus.memAck) begin
          if (!we_q && bus.ldMDR) mdr_d = bus.memRData;
          req_d   = 1'b0;
          we_d    = 1'b0;
          r_d     = 1'b1;
          armed_d = 1'b0;
          state_d = StReady;
        end else if (cnt_q == CntLast) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
          r_d     = 1'b1;
          armed_d = 1'b0;
          state_d = StReady;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      StReady: begin
        if (bus.ldMAR) mar_d = bus.Bus;
        if (bus.ldMDR && !bus.mioEn) mdr_d = bus.Bus;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  assign bus.MAROut   = mar_q;
  assign bus.MDROut   = mdr_q;
  assign bus.memAddr  = mar_q;
  assign bus.memWData = mdr_q;
  assign bus.R        = r_q;
  assign bus.memReq   = req_q;
  assign bus.memWe    = we_q;
  assign bus.memErr   = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl (TIMEOUT = 4).
module tb_mem_access_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;

  mem_access_ctrl_if bus_if ();

  mem_access_ctrl #(.TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs the cycles after mioEn is raised; ack_at < 0 means never ack.
  task automatic run_access(input int ack_at, output int n_req, output int n_we,
                            output int n_r, output int r_at, output int addr_bad,
                            output int wdata_bad, input logic [15:0] exp_addr,
                            input logic [15:0] exp_wdata);
    n_req = 0; n_we = 0; n_r = 0; r_at = -1; addr_bad = 0; wdata_bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus_if.memReq === 1'b1) begin
        n_req++;
        if (bus_if.memAddr !== exp_addr) addr_bad++;
        if (bus_if.memWData !== exp_wdata) wdata_bad++;
      end
      if (bus_if.memWe === 1'b1) n_we++;
      if (bus_if.R === 1'b1) begin
        n_r++;
        if (r_at < 0) r_at = i;
      end
      bus_if.memAck = (i == ack_at);
    end
    bus_if.memAck = 1'b0;
  endtask

  task automatic test_reset();
    step();
    step();
    n_tests++;
    if ({bus_if.R, bus_if.memReq, bus_if.memWe, bus_if.memErr} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0000",
               {bus_if.R, bus_if.memReq, bus_if.memWe, bus_if.memErr});
    end
    n_tests++;
    if ({bus_if.MAROut, bus_if.MDROut} !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_regs: got %h expected 0", {bus_if.MAROut, bus_if.MDROut});
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_write();
    int n_req, n_we, n_r, r_at, ab, wb;
    bus_if.Bus = 16'h3000; bus_if.ldMAR = 1'b1;
    step();
    bus_if.ldMAR = 1'b0; bus_if.Bus = 16'h1234; bus_if.ldMDR = 1'b1;
    step();
    bus_if.ldMDR = 1'b0;
    n_tests++;
    if (bus_if.MAROut !== 16'h3000 || bus_if.MDROut !== 16'h1234) begin
      n_fail++;
      $display("FAIL write_load: got MAR=%h MDR=%h expected 3000/1234",
               bus_if.MAROut, bus_if.MDROut);
    end
    bus_if.mioEn = 1'b1; bus_if.rw = 1'b1;
    run_access(2, n_req, n_we, n_r, r_at, ab, wb, 16'h3000, 16'h1234);
    n_tests++;
    if (n_req != 3 || n_we != 3) begin
      n_fail++;
      $display("FAIL write_req_cycles: got req=%0d we=%0d expected 3/3", n_req, n_we);
    end
    n_tests++;
    if (ab != 0 || wb != 0) begin
      n_fail++;
      $display("FAIL write_addr_data: got bad addr=%0d data=%0d expected 0/0", ab, wb);
    end
    n_tests++;
    if (n_r != 1 || r_at != 3) begin
      n_fail++;
      $display("FAIL write_r_pulse: got count=%0d at=%0d expected 1 at 3", n_r, r_at);
    end
    bus_if.mioEn = 1'b0;
    step();
  endtask

  task automatic test_read();
    int n_req, n_we, n_r, r_at, ab, wb;
    // Preload MDR with a different value so the read visibly updates it.
    bus_if.Bus = 16'hBEEF; bus_if.ldMDR = 1'b1;
    step();
    bus_if.mioEn = 1'b1; bus_if.rw = 1'b0; bus_if.memRData = 16'h1234;
    run_access(0, n_req, n_we, n_r, r_at, ab, wb, 16'h3000, 16'hBEEF);
    n_tests++;
    if (n_r != 1 || r_at != 1) begin
      n_fail++;
      $display("FAIL read_r_latency: got count=%0d at=%0d expected 1 at 1", n_r, r_at);
    end
    n_tests++;
    if (n_we != 0 || n_req != 1) begin
      n_fail++;
      $display("FAIL read_req_we: got req=%0d we=%0d expected 1/0", n_req, n_we);
    end
    n_tests++;
    if (bus_if.MDROut !== 16'h1234) begin
      n_fail++;
      $display("FAIL read_mdr: got %h expected 1234", bus_if.MDROut);
    end
    bus_if.ldMDR = 1'b0; bus_if.mioEn = 1'b0;
    step();
  endtask

  task automatic test_hold();
    int n_req, n_we, n_r, r_at, ab, wb, extra;
    bus_if.mioEn = 1'b1; bus_if.rw = 1'b0;
    run_access(0, n_req, n_we, n_r, r_at, ab, wb, 16'h3000, 16'h1234);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus_if.memReq === 1'b1) extra++;
    end
    n_tests++;
    if (n_req != 1 || extra != 0) begin
      n_fail++;
      $display("FAIL hold_no_rerequest: got req=%0d extra=%0d expected 1/0", n_req, extra);
    end
    bus_if.mioEn = 1'b0;
    step();
    bus_if.mioEn = 1'b1;
    step();
    n_tests++;
    if (bus_if.memReq !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_rearm: got memReq=%b expected 1", bus_if.memReq);
    end
    bus_if.memAck = 1'b1;
    step();
    bus_if.memAck = 1'b0;
    n_tests++;
    if (bus_if.R !== 1'b1 || bus_if.memReq !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_rearm_done: got R=%b memReq=%b expected 1/0",
               bus_if.R, bus_if.memReq);
    end
    bus_if.mioEn = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    int n_req, n_we, n_r, r_at, ab, wb;
    bus_if.mioEn = 1'b1; bus_if.rw = 1'b0; bus_if.ldMDR = 1'b1; bus_if.memRData = 16'hDEAD;
    run_access(-1, n_req, n_we, n_r, r_at, ab, wb, 16'h3000, 16'h1234);
    n_tests++;
    if (n_req != 4 || n_r != 1 || r_at != 4) begin
      n_fail++;
      $display("FAIL timeout_cycles: got req=%0d R=%0d at=%0d expected 4/1 at 4",
               n_req, n_r, r_at);
    end
    n_tests++;
    if (bus_if.memErr !== 1'b1 || bus_if.MDROut !== 16'h1234) begin
      n_fail++;
      $display("FAIL timeout_err_mdr: got err=%b MDR=%h expected 1/1234",
               bus_if.memErr, bus_if.MDROut);
    end
    bus_if.ldMDR = 1'b0; bus_if.mioEn = 1'b0;
    step();
  endtask

  task automatic test_stability();
    bus_if.Bus = 16'h5555; bus_if.ldMDR = 1'b1;
    step();
    bus_if.ldMDR = 1'b0;
    bus_if.mioEn = 1'b1; bus_if.rw = 1'b1;
    step();
    bus_if.Bus = 16'hFFFF; bus_if.ldMAR = 1'b1; bus_if.ldMDR = 1'b1;
    step();
    step();
    n_tests++;
    if (bus_if.memReq !== 1'b1 || bus_if.memAddr !== 16'h3000 ||
        bus_if.memWData !== 16'h5555) begin
      n_fail++;
      $display("FAIL stable_wait: got req=%b addr=%h wdata=%h expected 1/3000/5555",
               bus_if.memReq, bus_if.memAddr, bus_if.memWData);
    end
    bus_if.ldMAR = 1'b0; bus_if.ldMDR = 1'b0; bus_if.memAck = 1'b1;
    step();
    bus_if.memAck = 1'b0;
    n_tests++;
    if (bus_if.R !== 1'b1 || bus_if.MAROut !== 16'h3000 || bus_if.MDROut !== 16'h5555) begin
      n_fail++;
      $display("FAIL stable_after_r: got R=%b MAR=%h MDR=%h expected 1/3000/5555",
               bus_if.R, bus_if.MAROut, bus_if.MDROut);
    end
    n_tests++;
    if (bus_if.memErr !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: got %b expected 1", bus_if.memErr);
    end
    bus_if.mioEn = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    int late_r;
    bus_if.mioEn = 1'b1; bus_if.rw = 1'b1;
    step();
    n_tests++;
    if (bus_if.memReq !== 1'b1 || bus_if.memWe !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_pre: got req=%b we=%b expected 1/1", bus_if.memReq, bus_if.memWe);
    end
    #3;
    reset = 1'b1; bus_if.mioEn = 1'b0;
    #1;
    n_tests++;
    if ({bus_if.memReq, bus_if.memWe, bus_if.R, bus_if.memErr} !== 4'b0000) begin
      n_fail++;
      $display("FAIL areset_flags: got %b expected 0000",
               {bus_if.memReq, bus_if.memWe, bus_if.R, bus_if.memErr});
    end
    n_tests++;
    if ({bus_if.MAROut, bus_if.MDROut} !== 32'h0) begin
      n_fail++;
      $display("FAIL areset_regs: got %h expected 0", {bus_if.MAROut, bus_if.MDROut});
    end
    bus_if.memAck = 1'b1;
    #2;
    reset = 1'b0;
    late_r = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus_if.R === 1'b1 || bus_if.memReq === 1'b1) late_r++;
    end
    bus_if.memAck = 1'b0;
    n_tests++;
    if (late_r != 0) begin
      n_fail++;
      $display("FAIL areset_late_ack: got %0d active cycles expected 0", late_r);
    end
  endtask

  initial begin
    bus_if.Bus = 16'h0; bus_if.ldMAR = 1'b0; bus_if.ldMDR = 1'b0; bus_if.mioEn = 1'b0;
    bus_if.rw = 1'b0; bus_if.memRData = 16'h0; bus_if.memAck = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_hold();
    test_timeout();
    test_stability();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
